// File: rtl/ahb_apb_pkg.sv
// Shared types and bus encodings for the AHB-to-APB bridge.
// Latency: none (types, constants and a pure function only).
// Backpressure: n/a.
package ahb_apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_ERR1   = 3'd3,
        ST_ERR2   = 3'd4
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Wide enough for the largest allowed timeout (65535).
    localparam int WAIT_CNT_W = 16;

    // True for transfer types that carry a real access (NONSEQ/SEQ).
    function automatic logic is_active_trans(input logic [1:0] trans);
        logic act;
        case (trans)
            HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
            default:                   act = 1'b0;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Maps an AHB address onto one of NUM_SLV equally sized APB slave regions.
// Latency: purely combinational.
// Backpressure: none; a decode miss is reported through hit=0.
module apb_addr_decode #(
    parameter int                ADDR_W    = 32,
    parameter int                NUM_SLV   = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int                REGION_W  = 26,
    localparam int               IDX_W     = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
    input  logic [ADDR_W-1:0] haddr,
    output logic              hit,
    output logic [IDX_W-1:0]  index
);

    localparam int               RGN_W    = ADDR_W - REGION_W;
    localparam logic [RGN_W-1:0] BASE_RGN = BASE_ADDR[ADDR_W-1:REGION_W];

    logic [RGN_W-1:0] rgn;
    logic             unused_offset;

    assign rgn           = haddr[ADDR_W-1:REGION_W];
    // Offset bits inside a region do not take part in slave selection.
    assign unused_offset = ^haddr[REGION_W-1:0];

    // Region number relative to the window base selects the slave.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (rgn == BASE_RGN + RGN_W'(i)) begin
                hit   = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ahb_apb_bridge_v2.sv
// AHB-Lite slave to multi-slave APB master bridge with decode-miss and timeout errors.
// Latency: 2 cycles minimum (SETUP + one ACCESS); back-to-back transfers at 2 cycles each.
// Backpressure: hr_readyout held low in SETUP/ERR1 and in ACCESS until the selected pready.
module ahb_apb_bridge_v2
    import ahb_apb_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                NUM_SLV   = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int                REGION_W  = 26,
    parameter int                TIMEOUT   = 255
) (
    input  logic                      hclk,
    input  logic                      hresetn,
    input  logic                      hwrite,
    input  logic                      hready_in,
    input  logic [1:0]                htrans,
    input  logic [ADDR_W-1:0]         haddr,
    input  logic [DATA_W-1:0]         hwdata,
    output logic                      hr_readyout,
    output logic                      hresp,
    output logic [DATA_W-1:0]         hrdata,
    output logic [NUM_SLV-1:0]        psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr
);

    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q;
    logic                    write_q;
    logic [IDX_W-1:0]        sel_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

    logic                    dec_hit;
    logic [IDX_W-1:0]        dec_idx;
    logic                    accept;
    logic                    timeout_hit;
    logic                    pready_sel;
    logic                    pslverr_sel;
    logic [DATA_W-1:0]       prdata_sel;
    logic [NUM_SLV-1:0]      sel_onehot;

    apb_addr_decode #(
        .ADDR_W    (ADDR_W),
        .NUM_SLV   (NUM_SLV),
        .BASE_ADDR (BASE_ADDR),
        .REGION_W  (REGION_W)
    ) u_addr_decode (
        .haddr (haddr),
        .hit   (dec_hit),
        .index (dec_idx)
    );

    // Pick the response lines of the slave latched for the current transfer.
    always_comb begin
        pready_sel  = 1'b0;
        pslverr_sel = 1'b0;
        prdata_sel  = '0;
        sel_onehot  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_q == IDX_W'(i)) begin
                pready_sel    = pready[i];
                pslverr_sel   = pslverr[i];
                prdata_sel    = prdata[i*DATA_W +: DATA_W];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    // hr_readyout gates acceptance, so a new address phase can overlap a completing ACCESS.
    assign accept      = hready_in & is_active_trans(htrans) & hr_readyout;
    // Fires in the TIMEOUT-th consecutive ACCESS cycle without pready.
    assign timeout_hit = (state_q == ST_ACCESS) & ~pready_sel &
                         (wait_cnt_q == WAIT_CNT_W'(TIMEOUT - 1));
    // Counter is zero outside ACCESS, so it is already clear on entry.
    assign wait_cnt_d  = ((state_q == ST_ACCESS) && !pready_sel) ? wait_cnt_q + 1'b1 : '0;

    // State register.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (accept) state_d = dec_hit ? ST_SETUP : ST_ERR1;
                else        state_d = ST_IDLE;
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (timeout_hit || (pready_sel && pslverr_sel)) begin
                    state_d = ST_ERR1;
                end else if (pready_sel) begin
                    if (accept) state_d = dec_hit ? ST_SETUP : ST_ERR1;
                    else        state_d = ST_IDLE;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    // Transfer attributes captured at acceptance; write data captured leaving SETUP.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            addr_q     <= '0;
            write_q    <= 1'b0;
            sel_q      <= '0;
            wdata_q    <= '0;
            wait_cnt_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= haddr;
                write_q <= hwrite;
                sel_q   <= dec_idx;
            end
            if (state_q == ST_SETUP) begin
                wdata_q <= hwdata;
            end
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Bus outputs decoded from the current state.
    always_comb begin
        psel        = '0;
        penable     = 1'b0;
        hr_readyout = 1'b1;
        hresp       = HRESP_OKAY;
        hrdata      = '0;
        paddr       = addr_q;
        pwrite      = write_q;
        pwdata      = wdata_q;
        case (state_q)
            ST_SETUP: begin
                psel        = sel_onehot;
                hr_readyout = 1'b0;
                // AHB write data arrives in the data phase, which coincides with SETUP.
                pwdata      = hwdata;
            end
            ST_ACCESS: begin
                psel        = sel_onehot;
                penable     = 1'b1;
                hr_readyout = pready_sel & ~pslverr_sel & ~timeout_hit;
                hrdata      = pready_sel ? prdata_sel : '0;
            end
            ST_ERR1: begin
                hr_readyout = 1'b0;
                hresp       = HRESP_ERROR;
            end
            ST_ERR2: begin
                hresp       = HRESP_ERROR;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_apb_bridge_v2.sv
// Directed bench for the AHB-to-APB bridge: one task per scenario with inline checks.
// Latency: checks each cycle 2 time units after the rising edge.
// Backpressure: APB slaves are modelled by directly driven pready/pslverr vectors.
module tb_ahb_apb_bridge_v2;
    import ahb_apb_pkg::*;

    localparam int NS = 3;
    localparam logic [31:0] RD0 = 32'hA0A0_0000;
    localparam logic [31:0] RD1 = 32'hB1B1_1111;
    localparam logic [31:0] RD2 = 32'h1234_5678;

    logic            hclk = 1'b0;
    logic            hresetn;
    logic            hwrite, hready_in;
    logic [1:0]      htrans;
    logic [31:0]     haddr, hwdata;
    logic            hr_readyout, hresp;
    logic [31:0]     hrdata;
    logic [NS-1:0]   psel;
    logic            penable, pwrite;
    logic [31:0]     paddr, pwdata;
    logic [NS*32-1:0] prdata;
    logic [NS-1:0]   pready, pslverr;

    int total = 0;
    int bad   = 0;

    assign prdata = {RD2, RD1, RD0};

    always #5 hclk = ~hclk;

    ahb_apb_bridge_v2 #(.TIMEOUT(4)) dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .hwrite      (hwrite),
        .hready_in   (hready_in),
        .htrans      (htrans),
        .haddr       (haddr),
        .hwdata      (hwdata),
        .hr_readyout (hr_readyout),
        .hresp       (hresp),
        .hrdata      (hrdata),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic bus_idle();
        htrans  = HTRANS_IDLE;
        hwrite  = 1'b0;
        haddr   = '0;
        pready  = '0;
        pslverr = '0;
    endtask

    task automatic test_reset();
        bus_idle();
        hready_in = 1'b1;
        hwdata    = '0;
        hresetn   = 1'b1;
        #2;
        hresetn = 1'b0;
        #1;
        total++; if (psel !== 3'b000) begin bad++; $display("FAIL rst_psel got=%b exp=000", psel); end
        total++; if (penable !== 1'b0) begin bad++; $display("FAIL rst_penable got=%b exp=0", penable); end
        total++; if (pwrite !== 1'b0) begin bad++; $display("FAIL rst_pwrite got=%b exp=0", pwrite); end
        total++; if (paddr !== 32'h0) begin bad++; $display("FAIL rst_paddr got=%h exp=0", paddr); end
        total++; if (pwdata !== 32'h0) begin bad++; $display("FAIL rst_pwdata got=%h exp=0", pwdata); end
        total++; if (hrdata !== 32'h0) begin bad++; $display("FAIL rst_hrdata got=%h exp=0", hrdata); end
        total++; if (hresp !== 1'b0) begin bad++; $display("FAIL rst_hresp got=%b exp=0", hresp); end
        total++; if (hr_readyout !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", hr_readyout); end
        tick();
        hresetn = 1'b1;
    endtask

    task automatic test_write();
        haddr = 32'h8400_0010; hwrite = 1'b1; htrans = HTRANS_NONSEQ; #1;
        total++; if (hr_readyout !== 1'b1) begin bad++; $display("FAIL wr_accept_ready got=%b exp=1", hr_readyout); end
        tick(); bus_idle(); hwdata = 32'hDEAD_BEEF; pready = 3'b010; #1;
        total++; if (psel !== 3'b010) begin bad++; $display("FAIL wr_setup_psel got=%b exp=010", psel); end
        total++; if (penable !== 1'b0) begin bad++; $display("FAIL wr_setup_penable got=%b exp=0", penable); end
        total++; if (paddr !== 32'h8400_0010) begin bad++; $display("FAIL wr_setup_paddr got=%h exp=84000010", paddr); end
        total++; if (pwrite !== 1'b1) begin bad++; $display("FAIL wr_setup_pwrite got=%b exp=1", pwrite); end
        total++; if (pwdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_setup_pwdata got=%h exp=deadbeef", pwdata); end
        total++; if (hr_readyout !== 1'b0) begin bad++; $display("FAIL wr_setup_ready got=%b exp=0", hr_readyout); end
        tick(); hwdata = 32'h0; #1;
        total++; if (penable !== 1'b1) begin bad++; $display("FAIL wr_access_penable got=%b exp=1", penable); end
        total++; if (psel !== 3'b010) begin bad++; $display("FAIL wr_access_psel got=%b exp=010", psel); end
        total++; if (pwdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_access_pwdata got=%h exp=deadbeef", pwdata); end
        total++; if (hr_readyout !== 1'b1) begin bad++; $display("FAIL wr_access_ready got=%b exp=1", hr_readyout); end
        total++; if (hresp !== 1'b0) begin bad++; $display("FAIL wr_access_hresp got=%b exp=0", hresp); end
        tick(); pready = '0; #1;
        total++; if ({psel, penable, hr_readyout} !== 5'b00001) begin bad++; $display("FAIL wr_idle got=%b exp=00001", {psel, penable, hr_readyout}); end
    endtask

    task automatic test_read_wait();
        haddr = 32'h8800_0004; hwrite = 1'b0; htrans = HTRANS_NONSEQ; #1;
        tick(); bus_idle(); #1;
        total++; if (psel !== 3'b100) begin bad++; $display("FAIL rd_setup_psel got=%b exp=100", psel); end
        total++; if (pwrite !== 1'b0) begin bad++; $display("FAIL rd_setup_pwrite got=%b exp=0", pwrite); end
        total++; if (paddr !== 32'h8800_0004) begin bad++; $display("FAIL rd_setup_paddr got=%h exp=88000004", paddr); end
        for (int w = 0; w < 3; w++) begin
            tick(); #1;
            total++; if ({penable, hr_readyout} !== 2'b10) begin bad++; $display("FAIL rd_wait%0d got=%b exp=10", w, {penable, hr_readyout}); end
            total++; if (hrdata !== 32'h0) begin bad++; $display("FAIL rd_wait%0d_hrdata got=%h exp=0", w, hrdata); end
        end
        tick(); pready = 3'b100; #1;
        total++; if ({penable, hr_readyout} !== 2'b11) begin bad++; $display("FAIL rd_last got=%b exp=11", {penable, hr_readyout}); end
        total++; if (hrdata !== 32'h1234_5678) begin bad++; $display("FAIL rd_last_hrdata got=%h exp=12345678", hrdata); end
        tick(); pready = '0; #1;
        total++; if ({psel, hr_readyout} !== 4'b0001) begin bad++; $display("FAIL rd_idle got=%b exp=0001", {psel, hr_readyout}); end
        total++; if (hrdata !== 32'h0) begin bad++; $display("FAIL rd_idle_hrdata got=%h exp=0", hrdata); end
    endtask

    task automatic test_decode_miss();
        haddr = 32'h9000_0000; hwrite = 1'b0; htrans = HTRANS_NONSEQ; #1;
        tick(); bus_idle(); #1;
        total++; if ({psel, hresp, hr_readyout} !== 5'b00010) begin bad++; $display("FAIL miss_err1 got=%b exp=00010", {psel, hresp, hr_readyout}); end
        tick(); #1;
        total++; if ({psel, hresp, hr_readyout} !== 5'b00011) begin bad++; $display("FAIL miss_err2 got=%b exp=00011", {psel, hresp, hr_readyout}); end
        tick(); #1;
        total++; if ({hresp, hr_readyout} !== 2'b01) begin bad++; $display("FAIL miss_idle got=%b exp=01", {hresp, hr_readyout}); end
    endtask

    task automatic test_slverr();
        haddr = 32'h8000_0000; hwrite = 1'b1; htrans = HTRANS_NONSEQ; #1;
        tick(); bus_idle(); hwdata = 32'h5555_AAAA; #1;
        total++; if (psel !== 3'b001) begin bad++; $display("FAIL se_setup_psel got=%b exp=001", psel); end
        tick(); pready = 3'b001; pslverr = 3'b001; #1;
        total++; if ({penable, hr_readyout, hresp} !== 3'b100) begin bad++; $display("FAIL se_access got=%b exp=100", {penable, hr_readyout, hresp}); end
        tick(); bus_idle(); #1;
        total++; if ({psel, penable, hresp, hr_readyout} !== 6'b000010) begin bad++; $display("FAIL se_err1 got=%b exp=000010", {psel, penable, hresp, hr_readyout}); end
        tick(); #1;
        total++; if ({hresp, hr_readyout} !== 2'b11) begin bad++; $display("FAIL se_err2 got=%b exp=11", {hresp, hr_readyout}); end
        tick(); #1;
        total++; if ({hresp, hr_readyout} !== 2'b01) begin bad++; $display("FAIL se_idle got=%b exp=01", {hresp, hr_readyout}); end
    endtask

    task automatic test_timeout();
        haddr = 32'h8000_0020; hwrite = 1'b0; htrans = HTRANS_NONSEQ; #1;
        tick(); bus_idle(); #1;
        for (int w = 0; w < 4; w++) begin
            tick(); #1;
            total++; if ({psel, penable, hr_readyout} !== 5'b00110) begin bad++; $display("FAIL to_access%0d got=%b exp=00110", w, {psel, penable, hr_readyout}); end
        end
        tick(); #1;
        total++; if ({psel, penable, hresp, hr_readyout} !== 6'b000010) begin bad++; $display("FAIL to_err1 got=%b exp=000010", {psel, penable, hresp, hr_readyout}); end
        tick(); #1;
        total++; if ({hresp, hr_readyout} !== 2'b11) begin bad++; $display("FAIL to_err2 got=%b exp=11", {hresp, hr_readyout}); end
        tick(); #1;
        total++; if ({hresp, hr_readyout} !== 2'b01) begin bad++; $display("FAIL to_idle got=%b exp=01", {hresp, hr_readyout}); end
    endtask

    task automatic test_back_to_back();
        haddr = 32'h8000_0008; hwrite = 1'b0; htrans = HTRANS_NONSEQ; #1;
        tick(); bus_idle(); #1;
        total++; if (psel !== 3'b001) begin bad++; $display("FAIL b2b_setup0 got=%b exp=001", psel); end
        tick(); pready = 3'b001; haddr = 32'h8400_000C; htrans = HTRANS_NONSEQ; #1;
        total++; if (hr_readyout !== 1'b1) begin bad++; $display("FAIL b2b_access0_ready got=%b exp=1", hr_readyout); end
        total++; if (hrdata !== RD0) begin bad++; $display("FAIL b2b_access0_hrdata got=%h exp=%h", hrdata, RD0); end
        tick(); bus_idle(); pready = 3'b010; #1;
        total++; if ({psel, penable} !== 4'b0100) begin bad++; $display("FAIL b2b_setup1 got=%b exp=0100", {psel, penable}); end
        total++; if (paddr !== 32'h8400_000C) begin bad++; $display("FAIL b2b_setup1_paddr got=%h exp=8400000c", paddr); end
        tick(); #1;
        total++; if ({penable, hr_readyout} !== 2'b11) begin bad++; $display("FAIL b2b_access1 got=%b exp=11", {penable, hr_readyout}); end
        total++; if (hrdata !== RD1) begin bad++; $display("FAIL b2b_access1_hrdata got=%h exp=%h", hrdata, RD1); end
        tick(); pready = '0; #1;
        total++; if (psel !== 3'b000) begin bad++; $display("FAIL b2b_idle got=%b exp=000", psel); end
    endtask

    task automatic test_ignored();
        haddr = 32'h8000_0000; hwrite = 1'b1; htrans = HTRANS_BUSY; #1;
        total++; if ({hresp, hr_readyout} !== 2'b01) begin bad++; $display("FAIL busy_resp got=%b exp=01", {hresp, hr_readyout}); end
        tick(); htrans = HTRANS_NONSEQ; hready_in = 1'b0; #1;
        total++; if (psel !== 3'b000) begin bad++; $display("FAIL busy_no_psel got=%b exp=000", psel); end
        tick(); hready_in = 1'b1; bus_idle(); #1;
        total++; if ({psel, hr_readyout} !== 4'b0001) begin bad++; $display("FAIL nordy_no_psel got=%b exp=0001", {psel, hr_readyout}); end
    endtask

    task automatic test_reset_mid();
        haddr = 32'h8800_0000; hwrite = 1'b1; htrans = HTRANS_NONSEQ; #1;
        tick(); bus_idle(); hwdata = 32'hCAFE_F00D; #1;
        tick(); #1;
        total++; if (penable !== 1'b1) begin bad++; $display("FAIL rm_access got=%b exp=1", penable); end
        hresetn = 1'b0; #1;
        total++; if ({psel, penable, pwrite} !== 5'b00000) begin bad++; $display("FAIL rm_apb_ctl got=%b exp=00000", {psel, penable, pwrite}); end
        total++; if ({paddr, pwdata, hrdata} !== 96'h0) begin bad++; $display("FAIL rm_data got=%h exp=0", {paddr, pwdata, hrdata}); end
        total++; if ({hresp, hr_readyout} !== 2'b01) begin bad++; $display("FAIL rm_ahb got=%b exp=01", {hresp, hr_readyout}); end
        tick(); #1;
        total++; if ({psel, penable} !== 4'b0000) begin bad++; $display("FAIL rm_held got=%b exp=0000", {psel, penable}); end
        hresetn = 1'b1;
        haddr = 32'h8400_0000; hwrite = 1'b0; htrans = HTRANS_NONSEQ; #1;
        tick(); bus_idle(); #1;
        total++; if ({psel, penable} !== 4'b0100) begin bad++; $display("FAIL rm_first_setup got=%b exp=0100", {psel, penable}); end
        tick(); pready = 3'b010; #1;
        total++; if ({penable, hr_readyout} !== 2'b11) begin bad++; $display("FAIL rm_first_access got=%b exp=11", {penable, hr_readyout}); end
        tick(); pready = '0; #1;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_decode_miss();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_ignored();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
